// File: rtl/interleaver_pkg.sv
// Shared types and constants for the block interleaver address path.
package interleaver_pkg;

   localparam logic MODE_LINEAR    = 1'b0;
   localparam logic MODE_TRANSPOSE = 1'b1;

   localparam int DEF_ROW_W  = 6;
   localparam int DEF_COL_W  = 7;
   localparam int DEF_ADDR_W = DEF_ROW_W + DEF_COL_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/interleave_addr_gen_if.sv
// Control/address bundle between the interleaver control (master) and the address generator (slave).
interface interleave_addr_gen_if
   import interleaver_pkg::*;
#(
   parameter int ROW_W  = DEF_ROW_W,
   parameter int COL_W  = DEF_COL_W,
   parameter int ADDR_W = ROW_W + COL_W
) ();

   logic              start;
   logic [ROW_W-1:0]  cfg_rows;
   logic [COL_W-1:0]  cfg_cols;
   logic              mode;
   logic              auto_restart;
   logic              enable;
   logic [ADDR_W-1:0] addr;
   logic              addr_valid;
   logic              last;
   logic              done;
   logic              busy;
   logic              cfg_err;

   modport master (
      output start, cfg_rows, cfg_cols, mode, auto_restart, enable,
      input  addr, addr_valid, last, done, busy, cfg_err
   );

   modport slave (
      input  start, cfg_rows, cfg_cols, mode, auto_restart, enable,
      output addr, addr_valid, last, done, busy, cfg_err
   );

endinterface

// File: rtl/interleave_addr_gen_wrap_counter.sv
// Index counter that counts 0..limit and wraps back to 0; load0 clears it and wins over inc.
module wrap_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset_or_restart,
   input  logic         inc,
   input  logic         load0,
   input  logic [W-1:0] limit,
   output logic [W-1:0] value,
   output logic         at_limit
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_r;

   // Count register: clear, wrap at limit, or step by one.
   always_ff @(posedge clk or posedge reset_or_restart) begin
      if (reset_or_restart) begin
         count_r <= {W{1'b0}};
      end else if (load0) begin
         count_r <= {W{1'b0}};
      end else if (inc) begin
         if (at_limit) begin
            count_r <= {W{1'b0}};
         end else begin
            count_r <= count_r + ONE;
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign value    = count_r;
   assign at_limit = (count_r == limit);

endmodule

// File: rtl/interleave_addr_gen.sv
// Block interleaver address generator: walks a run-time rows x cols block in row-major or column-major order.
module interleave_addr_gen
   import interleaver_pkg::*;
#(
   parameter int ROW_W  = DEF_ROW_W,
   parameter int COL_W  = DEF_COL_W,
   parameter int ADDR_W = ROW_W + COL_W
) (
   input  logic                 clk,
   input  logic                 reset_or_restart,
   interleave_addr_gen_if.slave bus
);

   localparam logic [ROW_W-1:0]  ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
   localparam logic [COL_W-1:0]  COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_r, state_s;
   logic [ROW_W-1:0]  rows_r;
   logic [COL_W-1:0]  cols_r;
   logic              mode_r;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic              done_r;
   logic              cfg_err_r;

   logic              start_ok_s, cfg_bad_s, accept_s, last_s;
   logic              row_inc_s, col_inc_s, row_at_s, col_at_s;
   logic [ROW_W-1:0]  row_val_s, row_lim_s;
   logic [COL_W-1:0]  col_val_s, col_lim_s;

   assign row_lim_s = rows_r - ROW_ONE;
   assign col_lim_s = cols_r - COL_ONE;

   // The fast index steps on every accept; the slow one only when the fast one wraps.
   assign col_inc_s = accept_s && ((mode_r == MODE_LINEAR) || row_at_s);
   assign row_inc_s = accept_s && ((mode_r == MODE_TRANSPOSE) || col_at_s);

   wrap_counter #(.W(ROW_W)) u_row (
      .clk              (clk),
      .reset_or_restart (reset_or_restart),
      .inc              (row_inc_s),
      .load0            (start_ok_s),
      .limit            (row_lim_s),
      .value            (row_val_s),
      .at_limit         (row_at_s)
   );

   wrap_counter #(.W(COL_W)) u_col (
      .clk              (clk),
      .reset_or_restart (reset_or_restart),
      .inc              (col_inc_s),
      .load0            (start_ok_s),
      .limit            (col_lim_s),
      .value            (col_val_s),
      .at_limit         (col_at_s)
   );

   assign last_s = (state_r == ST_RUN) && (row_val_s == row_lim_s) && (col_val_s == col_lim_s);

   // Next-state and incremental address decode; a valid start overrides any accept.
   always_comb begin
      state_s    = state_r;
      addr_s     = addr_r;
      start_ok_s = 1'b0;
      cfg_bad_s  = 1'b0;
      accept_s   = 1'b0;

      if (bus.start) begin
         if ((bus.cfg_rows != {ROW_W{1'b0}}) && (bus.cfg_cols != {COL_W{1'b0}})) begin
            start_ok_s = 1'b1;
         end else begin
            cfg_bad_s = 1'b1;
         end
      end else begin
         start_ok_s = 1'b0;
      end

      if ((state_r == ST_RUN) && bus.enable && !start_ok_s) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end

      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (start_ok_s) begin
               state_s = ST_RUN;
            end else if (accept_s && last_s && !bus.auto_restart) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: state_s = ST_IDLE;
      endcase

      if (start_ok_s) begin
         addr_s = {ADDR_W{1'b0}};
      end else if (accept_s) begin
         if (last_s) begin
            addr_s = {ADDR_W{1'b0}};
         end else if (mode_r == MODE_LINEAR) begin
            addr_s = addr_r + ADDR_ONE;
         end else if (row_at_s) begin
            addr_s = {{(ADDR_W-COL_W){1'b0}}, col_val_s} + ADDR_ONE;
         end else begin
            addr_s = addr_r + {{(ADDR_W-COL_W){1'b0}}, cols_r};
         end
      end else begin
         addr_s = addr_r;
      end
   end

   // State, address, latched configuration and pulse flags.
   always_ff @(posedge clk or posedge reset_or_restart) begin
      if (reset_or_restart) begin
         state_r   <= ST_IDLE;
         addr_r    <= {ADDR_W{1'b0}};
         rows_r    <= {ROW_W{1'b0}};
         cols_r    <= {COL_W{1'b0}};
         mode_r    <= MODE_LINEAR;
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         done_r    <= accept_s && last_s;
         cfg_err_r <= cfg_bad_s;
         if (start_ok_s) begin
            rows_r <= bus.cfg_rows;
            cols_r <= bus.cfg_cols;
            mode_r <= bus.mode;
         end else begin
            rows_r <= rows_r;
            cols_r <= cols_r;
            mode_r <= mode_r;
         end
      end
   end

   assign bus.addr       = addr_r;
   assign bus.addr_valid = (state_r == ST_RUN);
   assign bus.busy       = (state_r == ST_RUN);
   assign bus.last       = last_s;
   assign bus.done       = done_r;
   assign bus.cfg_err    = cfg_err_r;

endmodule
